// File: rtl/addr_pipe_tracker.sv
// Tracks register/CSR destinations of in-flight instructions behind EX
// and reports forwarding selects plus the count of pending register writes.
module addr_pipe_tracker #(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12,
    parameter int NSRC   = 2,
    localparam int SW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEPTH-1:0]         bubble,
    input  logic [DEPTH-1:0]         flush,
    input  logic [REG_AW-1:0]        reg_dest_in,
    input  logic                     reg_we_in,
    input  logic [CSR_AW-1:0]        csr_dest_in,
    input  logic                     csr_we_in,
    input  logic [NSRC*REG_AW-1:0]   src_addr,
    input  logic [CSR_AW-1:0]        csr_src_addr,
    output logic [DEPTH*REG_AW-1:0]  reg_dest_out,
    output logic [DEPTH-1:0]         reg_we_out,
    output logic [DEPTH*CSR_AW-1:0]  csr_dest_out,
    output logic [DEPTH-1:0]         csr_we_out,
    output logic [NSRC*SW-1:0]       fwd_sel,
    output logic [SW-1:0]            csr_fwd_sel,
    output logic [SW-1:0]            pending
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("addr_pipe_tracker: DEPTH must be 1..4");
    end

    logic [REG_AW-1:0] rd_q  [DEPTH];
    logic              rwe_q [DEPTH];
    logic [CSR_AW-1:0] cd_q  [DEPTH];
    logic              cwe_q [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [REG_AW-1:0] up_rd;
        logic              up_rwe;
        logic [CSR_AW-1:0] up_cd;
        logic              up_cwe;

        if (k == 0) begin : g_head
            assign up_rd  = reg_dest_in;
            assign up_rwe = reg_we_in;
            assign up_cd  = csr_dest_in;
            assign up_cwe = csr_we_in;
        end else begin : g_body
            assign up_rd  = rd_q[k-1];
            assign up_rwe = rwe_q[k-1];
            assign up_cd  = cd_q[k-1];
            assign up_cwe = cwe_q[k-1];
        end

        // Bubble holds regardless of flush; a bubbled upstream entry is
        // still copied forward, leaving hazard handling to the controller.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q[k]  <= '0;
                rwe_q[k] <= 1'b0;
                cd_q[k]  <= '0;
                cwe_q[k] <= 1'b0;
            end else if (!bubble[k]) begin
                if (flush[k]) begin
                    rd_q[k]  <= '0;
                    rwe_q[k] <= 1'b0;
                    cd_q[k]  <= '0;
                    cwe_q[k] <= 1'b0;
                end else begin
                    rd_q[k]  <= up_rd;
                    rwe_q[k] <= up_rwe;
                    cd_q[k]  <= up_cd;
                    cwe_q[k] <= up_cwe;
                end
            end
        end

        assign reg_dest_out[k*REG_AW +: REG_AW] = rd_q[k];
        assign reg_we_out[k]                    = rwe_q[k];
        assign csr_dest_out[k*CSR_AW +: CSR_AW] = cd_q[k];
        assign csr_we_out[k]                    = cwe_q[k];
    end

    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (rwe_q[k] && rd_q[k] != '0 &&
                    rd_q[k] == src_addr[i*REG_AW +: REG_AW]) begin
                    fwd_sel[i*SW +: SW] = SW'(k + 1);
                end
            end
        end
    end

    always_comb begin
        csr_fwd_sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (cwe_q[k] && cd_q[k] == csr_src_addr) begin
                csr_fwd_sel = SW'(k + 1);
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (rwe_q[k] && rd_q[k] != '0) begin
                pending = pending + SW'(1);
            end
        end
    end

endmodule
